// File: rtl/resblock_stream.sv
// Pixel-serial residual block: out = x + conv2(act(conv1(pre(x)))), 1x1 convs.
// One shared MAC, valid/ready on both sides, one pixel in flight.
module resblock_stream #(
  parameter int DATA_WIDTH      = 8,
  parameter int CHANNELS        = 4,
  parameter int BOTTLENECK      = 0,
  parameter int FRAC_BITS       = 0,
  parameter int ACC_WIDTH       = 24,
  parameter int PIXELS          = 4,
  parameter int START_FROM_RELU = 0,
  parameter int END_WITH_RELU   = 0,
  parameter int SLOPE_SMALL     = 0,
  localparam int M = (BOTTLENECK != 0) ? CHANNELS / 2 : CHANNELS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0]    in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [M*CHANNELS*DATA_WIDTH-1:0]  weights1,
  input  logic [M*DATA_WIDTH-1:0]           bias1,
  input  logic [CHANNELS*M*DATA_WIDTH-1:0]  weights2,
  input  logic [CHANNELS*DATA_WIDTH-1:0]    bias2,
  output logic [CHANNELS*DATA_WIDTH-1:0]    out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int CW = $clog2(CHANNELS + 1);
  localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic signed [AW-1:0] L_MAX = AW'((1 <<< (DW - 1)) - 1);
  localparam logic signed [AW-1:0] L_MIN = ~L_MAX;

  typedef enum logic [1:0] {
    S_IDLE, S_CONV1, S_CONV2, S_OUT
  } state_t;

  function automatic logic signed [AW-1:0] ext(
    input logic signed [DW-1:0] v);
    return {{(AW-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic signed [AW-1:0] act(
    input logic signed [AW-1:0] v);
    if (!v[AW-1])
      return v;
    else if (SLOPE_SMALL != 0)
      return v >>> 3;
    else
      return '0;
  endfunction

  function automatic logic signed [DW-1:0] sat(
    input logic signed [AW-1:0] v);
    if (v > L_MAX)
      return L_MAX[DW-1:0];
    else if (v < L_MIN)
      return L_MIN[DW-1:0];
    else
      return v[DW-1:0];
  endfunction

  state_t                        r_state;
  logic                          r_in_ready;
  logic                          r_out_valid;
  logic                          r_out_last;
  logic [CHANNELS*DW-1:0]        r_x;
  logic [M*DW-1:0]               r_mid;
  logic [CHANNELS*DW-1:0]        r_out;
  logic signed [AW-1:0]          r_acc;
  logic [CW-1:0]                 r_i;
  logic [CW-1:0]                 r_j;
  logic [PW-1:0]                 r_cnt;

  logic                          w_conv1;
  int                            w_ii;
  int                            w_jj;
  logic signed [DW-1:0]          w_a;
  logic signed [DW-1:0]          w_b;
  logic signed [DW-1:0]          w_bias;
  logic signed [DW-1:0]          w_xj;
  logic signed [DW-1:0]          w_xi;
  logic signed [AW-1:0]          w_xa;
  logic signed [2*DW-1:0]        w_prod;
  logic signed [AW-1:0]          w_sum;
  logic signed [AW-1:0]          w_shr;
  logic signed [DW-1:0]          w_mid;
  logic signed [DW-1:0]          w_y;
  logic signed [DW:0]            w_rs;
  logic signed [DW-1:0]          w_r;
  logic signed [AW-1:0]          w_rx;
  logic signed [DW-1:0]          w_o;
  logic                          w_in_last;
  logic                          w_out_last;

  always_comb begin
    w_conv1 = (r_state == S_CONV1);
    w_ii    = int'(r_i);
    w_jj    = int'(r_j);
    w_xj    = '0;
    w_xi    = '0;
    w_a     = '0;
    w_b     = '0;
    w_bias  = '0;
    w_xa    = '0;
    if (w_conv1) begin
      w_xj   = r_x[w_jj*DW +: DW];
      w_xa   = act(ext(w_xj));
      w_a    = (START_FROM_RELU != 0) ? w_xa[DW-1:0] : w_xj;
      w_b    = weights1[(w_ii*CHANNELS + w_jj)*DW +: DW];
      w_bias = bias1[w_ii*DW +: DW];
    end else begin
      w_a    = r_mid[w_jj*DW +: DW];
      w_b    = weights2[(w_ii*M + w_jj)*DW +: DW];
      w_bias = bias2[w_ii*DW +: DW];
      w_xi   = r_x[w_ii*DW +: DW];
    end
    w_prod = w_a * w_b;
    // First term of each dot product seeds the accumulator with the bias
    w_sum  = ((r_j == '0) ? (ext(w_bias) <<< FRAC_BITS) : r_acc)
           + {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
    w_shr  = w_sum >>> FRAC_BITS;
    w_mid  = sat(act(w_shr));
    w_y    = sat(w_shr);
    w_rs   = {w_y[DW-1], w_y} + {w_xi[DW-1], w_xi};
    w_r    = sat({{(AW-DW-1){w_rs[DW]}}, w_rs});
    w_rx   = act(ext(w_r));
    w_o    = (END_WITH_RELU != 0) ? w_rx[DW-1:0] : w_r;
    w_in_last  = w_conv1 ? (r_j == CW'(CHANNELS - 1))
                         : (r_j == CW'(M - 1));
    w_out_last = w_conv1 ? (r_i == CW'(M - 1))
                         : (r_i == CW'(CHANNELS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out       <= '0;
      r_x         <= '0;
      r_mid       <= '0;
      r_acc       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x        <= in_data;
            r_i        <= '0;
            r_j        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_CONV1;
          end
        end
        S_CONV1, S_CONV2: begin
          r_acc <= w_sum;
          if (w_in_last) begin
            r_j <= '0;
            if (w_conv1)
              r_mid[w_ii*DW +: DW] <= w_mid;
            else
              r_out[w_ii*DW +: DW] <= w_o;
            if (w_out_last) begin
              r_i <= '0;
              if (w_conv1) begin
                r_state <= S_CONV2;
              end else begin
                r_state     <= S_OUT;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_cnt == PW'(PIXELS - 1));
              end
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_cnt <= (r_cnt == PW'(PIXELS - 1)) ? '0 : r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out;

endmodule
